// File: rtl/rgb332_to_hsv.sv
// ============================================================================
// rgb332_to_hsv
// ----------------------------------------------------------------------------
// Sequential converter from an 8-bit RGB332 pixel word back to the 12-sector
// hue / 3-bit saturation / 3-bit value form that the pixel colour generator
// consumes. One restoring divider is shared by the saturation and hue
// divisions. Each division takes six cycles and produces one quotient bit
// per cycle, MSB first.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   color is valid
//   in_ready   block can accept a pixel (high only while idle)
//   color      pixel word: r=[7:5], g=[4:2], b2=[1:0]
//   out_valid  h/s/v result valid, held until accepted
//   out_ready  consumer accepts the result
//   h          hue sector 0..11
//   s          saturation 0..7
//   v          value 0..7
//
// Build option
//   RGB2HSV_GRAY_BYPASS_EN  when defined, grey inputs (delta == 0) skip both
//                           divisions and go straight from CALC to DONE.
//                           Chromatic inputs behave the same in both builds.
//
// Latency: for an accept at edge T, out_valid rises at edge T+14. With the
// gray bypass, a grey input raises out_valid at edge T+2. out_valid is
// registered, so it rises one edge after the FSM enters DONE. By then h/s/v
// are already settled.
// ============================================================================
module rgb332_to_hsv (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] color,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] h,
    output logic [2:0] s,
    output logic [2:0] v
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_DIV_S,
        ST_DIV_H,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Latched channel values. Blue is widened from 2 to 3 bits at the accept
    // edge.
    logic [2:0]  r_r3;
    logic [2:0]  r_g3;
    logic [2:0]  r_b3;

    // Values decoded in CALC and kept for the two division phases.
    logic [2:0]  r_mx;
    logic [2:0]  r_delta;
    logic [3:0]  r_base;
    logic        r_num_neg;
    logic [2:0]  r_num_abs;
    logic [2:0]  r_sat_q;

    // Shared restoring divider state.
    logic [5:0]  r_dvd;
    logic [3:0]  r_dvs;
    logic [5:0]  r_rem;
    logic [2:0]  r_quot;
    logic [2:0]  r_cnt;

    // Output registers.
    logic [3:0]  r_h;
    logic [2:0]  r_s;
    logic [2:0]  r_v;
    logic        r_out_valid;

    // Combinational decode of the latched pixel.
    logic [2:0]  w_mx;
    logic [2:0]  w_mn;
    logic [2:0]  w_delta;
    logic [3:0]  w_base;
    logic [3:0]  w_num;
    logic        w_num_neg;
    logic [2:0]  w_num_abs;

    // Divider step signals.
    logic        w_ge;
    logic [5:0]  w_shift;
    logic [5:0]  w_sub;
    logic [5:0]  w_rem_next;
    logic        w_qbit;
    logic [2:0]  w_quot_next;

    // Hue assembly.
    logic [1:0]  w_q;
    logic [4:0]  w_hue_raw;
    logic [3:0]  w_hue;

    logic        w_accept;
    logic        w_last_step;
    logic        w_handoff;

    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_last_step = (r_cnt == 3'd5);
    assign w_handoff   = r_out_valid && out_ready;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign h         = r_h;
    assign s         = r_s;
    assign v         = r_v;

    // Pick the max channel with r > g > b priority on ties. Then form the
    // sector base and the signed difference of the two other channels. The
    // minimum is found separately because it does not depend on the tie order.
    always_comb begin
        w_mx   = r_r3;
        w_base = 4'd0;
        w_num  = {1'b0, r_g3} - {1'b0, r_b3};
        if ((r_r3 >= r_g3) && (r_r3 >= r_b3)) begin
            w_mx   = r_r3;
            w_base = 4'd0;
            w_num  = {1'b0, r_g3} - {1'b0, r_b3};
        end else if (r_g3 >= r_b3) begin
            w_mx   = r_g3;
            w_base = 4'd4;
            w_num  = {1'b0, r_b3} - {1'b0, r_r3};
        end else begin
            w_mx   = r_b3;
            w_base = 4'd8;
            w_num  = {1'b0, r_r3} - {1'b0, r_g3};
        end

        w_mn = r_r3;
        if (r_g3 < w_mn) begin
            w_mn = r_g3;
        end
        if (r_b3 < w_mn) begin
            w_mn = r_b3;
        end
    end

    assign w_delta   = w_mx - w_mn;
    assign w_num_neg = w_num[3];
    assign w_num_abs = w_num_neg ? 3'(4'd0 - w_num) : w_num[2:0];

    // One restoring step. Shift the next dividend bit into the partial
    // remainder. Subtract the divisor only when the remainder is large enough.
    // The compare uses one extra bit, so a shifted value that overflows six
    // bits still compares correctly.
    assign w_shift     = {r_rem[4:0], r_dvd[5]};
    assign w_ge        = ({r_rem, r_dvd[5]} >= {3'b000, r_dvs});
    assign w_sub       = w_shift - {2'b00, r_dvs};
    assign w_qbit      = w_ge;
    assign w_rem_next  = w_ge ? w_sub : w_shift;
    assign w_quot_next = {r_quot[1:0], w_qbit};

    // hue = (base +/- q) mod 12. A negative offset adds 12 before
    // subtracting, so the sum never underflows. One conditional subtract then
    // folds the result back into 0..11.
    assign w_q       = w_quot_next[1:0];
    assign w_hue_raw = r_num_neg ? ({1'b0, r_base} + 5'd12 - {3'b000, w_q})
                                 : ({1'b0, r_base} + {3'b000, w_q});
    assign w_hue     = (w_hue_raw >= 5'd12) ? 4'(w_hue_raw - 5'd12)
                                            : w_hue_raw[3:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. DONE only releases when the registered out_valid has
    // actually been seen together with out_ready. This means a consumer that
    // holds out_ready high early cannot make the block skip its own result.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
`ifdef RGB2HSV_GRAY_BYPASS_EN
                if (w_delta == 3'd0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_DIV_S;
                end
`else
                w_state_next = ST_DIV_S;
`endif
            end
            ST_DIV_S: begin
                if (w_last_step) begin
                    w_state_next = ST_DIV_H;
                end
            end
            ST_DIV_H: begin
                if (w_last_step) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_handoff) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath. The accept edge widens b2 to 3 bits by repeating its MSB.
    // CALC registers the decode and loads delta*7 / mx into the divider. The
    // last saturation step stores s and reloads the divider with
    // (4|num| + delta) / (2*delta). The last hue step writes h/s/v, which
    // happens only on entry to DONE. Zero divisors cannot be avoided for
    // greys, so their quotients are discarded: s is forced to 0 when mx == 0,
    // and h is forced to 0 when delta == 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r3      <= 3'd0;
            r_g3      <= 3'd0;
            r_b3      <= 3'd0;
            r_mx      <= 3'd0;
            r_delta   <= 3'd0;
            r_base    <= 4'd0;
            r_num_neg <= 1'b0;
            r_num_abs <= 3'd0;
            r_sat_q   <= 3'd0;
            r_dvd     <= 6'd0;
            r_dvs     <= 4'd0;
            r_rem     <= 6'd0;
            r_quot    <= 3'd0;
            r_cnt     <= 3'd0;
            r_h       <= 4'd0;
            r_s       <= 3'd0;
            r_v       <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_r3 <= color[7:5];
                        r_g3 <= color[4:2];
                        r_b3 <= {color[1:0], color[1]};
                    end
                end
                ST_CALC: begin
                    r_mx      <= w_mx;
                    r_delta   <= w_delta;
                    r_base    <= w_base;
                    r_num_neg <= w_num_neg;
                    r_num_abs <= w_num_abs;
                    r_dvd     <= {w_delta, 3'b000} - {3'b000, w_delta};
                    r_dvs     <= {1'b0, w_mx};
                    r_rem     <= 6'd0;
                    r_quot    <= 3'd0;
                    r_cnt     <= 3'd0;
`ifdef RGB2HSV_GRAY_BYPASS_EN
                    if (w_delta == 3'd0) begin
                        r_h <= 4'd0;
                        r_s <= 3'd0;
                        r_v <= w_mx;
                    end
`endif
                end
                ST_DIV_S: begin
                    r_dvd  <= {r_dvd[4:0], 1'b0};
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_next;
                    r_cnt  <= r_cnt + 3'd1;
                    if (w_last_step) begin
                        r_sat_q <= (r_mx == 3'd0) ? 3'd0 : w_quot_next;
                        r_dvd   <= {1'b0, r_num_abs, 2'b00} + {3'b000, r_delta};
                        r_dvs   <= {r_delta, 1'b0};
                        r_rem   <= 6'd0;
                        r_quot  <= 3'd0;
                        r_cnt   <= 3'd0;
                    end
                end
                ST_DIV_H: begin
                    r_dvd  <= {r_dvd[4:0], 1'b0};
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_next;
                    r_cnt  <= r_cnt + 3'd1;
                    if (w_last_step) begin
                        r_h   <= (r_delta == 3'd0) ? 4'd0 : w_hue;
                        r_s   <= r_sat_q;
                        r_v   <= r_mx;
                        r_cnt <= 3'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // out_valid rises on the first DONE cycle. It stays high until the
    // handshake edge, and it is low in every other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_out_valid <= !w_handoff;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rgb332_to_hsv.sv
// ============================================================================
// tb_rgb332_to_hsv
// ----------------------------------------------------------------------------
// Directed testbench for rgb332_to_hsv. Every expected h/s/v was worked out
// by hand from the RGB332 -> HSV definition. Grey latency follows
// RGB2HSV_GRAY_BYPASS_EN.
// ============================================================================
module tb_rgb332_to_hsv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] color = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] h;
    logic [2:0] s;
    logic [2:0] v;

    int checks = 0;
    int errors = 0;

`ifdef RGB2HSV_GRAY_BYPASS_EN
    localparam int GRAY_LAT = 2;
`else
    localparam int GRAY_LAT = 14;
`endif

    // Chromatic vectors: color, expected h, s, v.
    localparam logic [7:0] VC [8] = '{8'hF0, 8'hE2, 8'h1C, 8'hE0,
                                      8'h03, 8'h6D, 8'h4A, 8'h2E};
    localparam logic [3:0] VH [8] = '{4'd1, 4'd11, 4'd4, 4'd0,
                                      4'd8, 4'd2,  4'd8, 4'd7};
    localparam logic [2:0] VS [8] = '{3'd7, 3'd7, 3'd7, 3'd7,
                                      3'd7, 3'd2, 3'd4, 3'd5};
    localparam logic [2:0] VV [8] = '{3'd7, 3'd7, 3'd7, 3'd7,
                                      3'd7, 3'd3, 3'd5, 3'd5};

    rgb332_to_hsv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .color     (color),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .h         (h),
        .s         (s),
        .v         (v)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one accept edge. The caller starts #1 after an edge, while idle.
    task automatic accept(input logic [7:0] c);
        color    = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept until out_valid is seen, or return -1.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid);
        end
        checks++;
        if ({h, s, v} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_hsv: got h=%0d s=%0d v=%0d expected 0/0/0", h, s, v);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
    endtask

    task automatic test_chromatic();
        int lat;
        for (int k = 0; k < 8; k++) begin
            accept(VC[k]);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_in_ready[%02h]: got %0b expected 0", VC[k], in_ready);
            end
            wait_out(lat);
            checks++;
            if (lat != 14) begin
                errors++;
                $display("[TB] FAIL latency[%02h]: got %0d expected 14", VC[k], lat);
            end
            checks++;
            if (h !== VH[k] || s !== VS[k] || v !== VV[k]) begin
                errors++;
                $display("[TB] FAIL hsv[%02h]: got h=%0d s=%0d v=%0d expected h=%0d s=%0d v=%0d",
                         VC[k], h, s, v, VH[k], VS[k], VV[k]);
            end
            handoff();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL after_handoff[%02h]: got in_ready=%0b out_valid=%0b expected 1/0",
                         VC[k], in_ready, out_valid);
            end
            checks++;
            if (h !== VH[k]) begin
                errors++;
                $display("[TB] FAIL hold_after_handoff[%02h]: got h=%0d expected %0d", VC[k], h, VH[k]);
            end
        end
    endtask

    task automatic test_gray();
        int lat;
        accept(8'h00);
        wait_out(lat);
        checks++;
        if (lat != GRAY_LAT) begin
            errors++;
            $display("[TB] FAIL gray_latency[00]: got %0d expected %0d", lat, GRAY_LAT);
        end
        checks++;
        if (h !== 4'd0 || s !== 3'd0 || v !== 3'd0) begin
            errors++;
            $display("[TB] FAIL gray_hsv[00]: got h=%0d s=%0d v=%0d expected 0/0/0", h, s, v);
        end
        handoff();
        accept(8'hFF);
        wait_out(lat);
        checks++;
        if (lat != GRAY_LAT) begin
            errors++;
            $display("[TB] FAIL gray_latency[FF]: got %0d expected %0d", lat, GRAY_LAT);
        end
        checks++;
        if (h !== 4'd0 || s !== 3'd0 || v !== 3'd7) begin
            errors++;
            $display("[TB] FAIL gray_hsv[FF]: got h=%0d s=%0d v=%0d expected 0/0/7", h, s, v);
        end
        handoff();
    endtask

    task automatic test_backpressure();
        int lat;
        accept(8'h6D);
        wait_out(lat);
        checks++;
        if (lat != 14) begin
            errors++;
            $display("[TB] FAIL bp_latency: got %0d expected 14", lat);
        end
        // A new pixel is offered while the result waits. It must not be taken.
        color    = 8'hE0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                h !== 4'd2 || s !== 3'd2 || v !== 3'd3) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: got ov=%0b ir=%0b h=%0d s=%0d v=%0d expected 1/0/2/2/3",
                         i, out_valid, in_ready, h, s, v);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_release: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || h !== 4'd2) begin
            errors++;
            $display("[TB] FAIL bp_no_accept_in_done: got in_ready=%0b h=%0d expected 1/2", in_ready, h);
        end
    endtask

    task automatic test_back_to_back();
        int acc_edges[$];
        int results = 0;
        logic acc;
        color     = 8'h2E;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) acc_edges.push_back(i);
            if (out_valid) begin
                results++;
                checks++;
                if (h !== 4'd7 || s !== 3'd5 || v !== 3'd5) begin
                    errors++;
                    $display("[TB] FAIL b2b_hsv[%0d]: got h=%0d s=%0d v=%0d expected 7/5/5", results, h, s, v);
                end
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        checks++;
        if (acc_edges.size() != 4 || results != 3) begin
            errors++;
            $display("[TB] FAIL b2b_counts: got accepts=%0d results=%0d expected 4/3",
                     acc_edges.size(), results);
        end
        for (int k = 1; k < acc_edges.size(); k++) begin
            checks++;
            if (acc_edges[k] - acc_edges[k-1] != 16) begin
                errors++;
                $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected 16",
                         k, acc_edges[k] - acc_edges[k-1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        accept(8'hF0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || h !== 4'd0 || s !== 3'd0 || v !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got ov=%0b h=%0d s=%0d v=%0d expected 0/0/0/0",
                     out_valid, h, s, v);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_in_ready: got %0b expected 1", in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_stale: got out_valid seen=%0b expected 0", seen);
        end
    endtask

    initial begin
        $display("[TB] starting rgb332_to_hsv bench");
        test_reset();
        test_chromatic();
        test_gray();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
